// File: rtl/bu_pipe.sv
// ============================================================================
// Module      : bu_pipe
// Description : Registered branch-resolution stage. Evaluates the bu_op_t
//               compare set, computes target / corrected next PC, flags
//               mispredictions, and buffers results in a 2-entry skid buffer
//               with valid/ready handshakes and flush.
//               Optional macro BU_PIPE_STATS_EN enables resolution counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef XLEN
`define XLEN 32
`endif

package bu_pipe_pkg;
  typedef enum logic [2:0] {
    BU_EQ  = 3'd0,
    BU_NE  = 3'd1,
    BU_LT  = 3'd2,
    BU_GE  = 3'd3,
    BU_LTU = 3'd4,
    BU_GEU = 3'd5
  } bu_op_t;
endpackage

module bu_pipe
  import bu_pipe_pkg::*;
#(
  parameter int XLEN       = `XLEN,
  parameter int ILEN_BYTES = 4
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_valid,
  output logic            o_in_ready,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  input  bu_op_t          i_op,
  input  logic            i_jump,
  input  logic [XLEN-1:0] i_pc,
  input  logic [XLEN-1:0] i_imm,
  input  logic            i_pred_taken,
  input  logic            i_flush,
  output logic            o_valid,
  input  logic            i_out_ready,
  output logic            o_take,
  output logic [XLEN-1:0] o_target,
  output logic [XLEN-1:0] o_next_pc,
  output logic            o_mispredict,
  output logic [31:0]     o_stat_resolved,
  output logic [31:0]     o_stat_mispredict
);

  // Payload layout: {take, mispredict, next_pc, target}
  localparam int             PW       = 2 * XLEN + 2;
  localparam logic [XLEN-1:0] ILEN_INC = XLEN'(ILEN_BYTES);

  logic            take;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] next_pc;
  logic            mispredict;
  logic [PW-1:0]   new_data;

  logic            m_valid;
  logic [PW-1:0]   m_data;
  logic            s_valid;
  logic [PW-1:0]   s_data;

  logic            accept;
  logic            consume;

  // Resolve the branch combinationally from the incoming request.
  always_comb begin
    take = 1'b0;
    unique case (i_op)
      BU_EQ:   take = (i_a == i_b);
      BU_NE:   take = (i_a != i_b);
      BU_LT:   take = ($signed(i_a) <  $signed(i_b));
      BU_GE:   take = ($signed(i_a) >= $signed(i_b));
      BU_LTU:  take = (i_a <  i_b);
      BU_GEU:  take = (i_a >= i_b);
      default: take = 1'b0;
    endcase
    if (i_jump) take = 1'b1;
    target     = i_pc + i_imm;
    next_pc    = take ? target : (i_pc + ILEN_INC);
    mispredict = (take != i_pred_taken);
    new_data   = {take, mispredict, next_pc, target};
  end

  // Ready depends only on the skid register, so no path from i_out_ready.
  assign o_in_ready = !s_valid;
  // A request arriving alongside a flush is discarded.
  assign accept     = i_valid && o_in_ready && !i_flush;
  assign consume    = m_valid && i_out_ready;

  // Skid buffer: M feeds the outputs, S absorbs one entry while M stalls.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      m_valid <= 1'b0;
      s_valid <= 1'b0;
      m_data  <= '0;
      s_data  <= '0;
    end else if (i_flush) begin
      m_valid <= 1'b0;
      s_valid <= 1'b0;
    end else if (consume) begin
      if (s_valid) begin
        m_data  <= s_data;
        m_valid <= 1'b1;
        s_valid <= 1'b0;
      end else if (accept) begin
        m_data  <= new_data;
        m_valid <= 1'b1;
      end else begin
        m_valid <= 1'b0;
      end
    end else if (!m_valid) begin
      if (accept) begin
        m_data  <= new_data;
        m_valid <= 1'b1;
      end
    end else if (accept) begin
      s_data  <= new_data;
      s_valid <= 1'b1;
    end
  end

  assign o_valid      = m_valid;
  assign o_take       = m_data[PW-1];
  assign o_mispredict = m_data[PW-2];
  assign o_next_pc    = m_data[2*XLEN-1:XLEN];
  assign o_target     = m_data[XLEN-1:0];

`ifdef BU_PIPE_STATS_EN
  logic [31:0] stat_resolved;
  logic [31:0] stat_mispredict;

  // Saturating counters of delivered results; a flush-cycle handshake counts.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      stat_resolved   <= '0;
      stat_mispredict <= '0;
    end else if (consume) begin
      if (stat_resolved != 32'hFFFF_FFFF) stat_resolved <= stat_resolved + 32'd1;
      if (o_mispredict && (stat_mispredict != 32'hFFFF_FFFF))
        stat_mispredict <= stat_mispredict + 32'd1;
    end
  end

  assign o_stat_resolved   = stat_resolved;
  assign o_stat_mispredict = stat_mispredict;
`else
  assign o_stat_resolved   = 32'd0;
  assign o_stat_mispredict = 32'd0;
`endif

endmodule

`default_nettype wire

// File: doc/bu_pipe.md
# bu_pipe

Registered, parametrised branch-resolution stage for the cotm32 execute path. Evaluates the `bu_op_t` compare set on `XLEN`-wide operands, computes branch target and corrected next PC, and flags mispredictions against the fetch-time prediction. Results are buffered in a 2-entry skid buffer with valid/ready handshakes on both sides and a flush input. Optional resolution statistics counters.

## Interface
- `XLEN`, default `` `XLEN ``: operand, PC and immediate width.
- `ILEN_BYTES`, default 4: fall-through PC increment.
- `i_clk` in 1: clock, rising edge.
- `i_rst_n` in 1: reset, asynchronous, active-low.
- `i_valid` in 1: upstream request valid.
- `o_in_ready` out 1: request accepted when `i_valid && o_in_ready`.
- `i_a`, `i_b` in XLEN: compare operands.
- `i_op` in `bu_op_t`: BU_EQ/NE/LT/GE/LTU/GEU.
- `i_jump` in 1: unconditional, forces take.
- `i_pc`, `i_imm` in XLEN: branch PC, sign-extended offset.
- `i_pred_taken` in 1: fetch prediction.
- `i_flush` in 1: discard all buffered and incoming entries.
- `o_valid` out 1: result valid.
- `i_out_ready` in 1: downstream accepts result.
- `o_take` out 1: branch resolved taken.
- `o_target` out XLEN: `i_pc + i_imm`.
- `o_next_pc` out XLEN: `o_take ? o_target : i_pc + ILEN_BYTES`.
- `o_mispredict` out 1: `o_take != i_pred_taken`.
- `o_stat_resolved`, `o_stat_mispredict` out 32: statistics counters.

## Operation
- Compare: EQ/NE equality; LT/GE signed two's complement; LTU/GEU unsigned. Undefined `i_op` encodings give take=0 unless `i_jump`.
- `i_jump`=1 gives take=1 regardless of op/operands.
- Additions modulo 2^XLEN; wrap-around silently discarded.
- All result fields computed combinationally from inputs and captured on accept; outputs driven only from registers.
- Storage: main register M (drives outputs) and skid register S, each with a valid bit.
- `o_valid` = M.valid; `o_in_ready` = !S.valid.
- Accept with M empty, or M consumed this cycle and S empty: entry loads M.
- Accept with M full and not consumed: entry loads S.
- M consumed and S valid: S moves to M, S cleared; a simultaneous accept is impossible (`o_in_ready`=0).
- Output payload held stable while `o_valid && !i_out_ready`.
- Flush: M.valid and S.valid cleared next cycle; a request presented in the flush cycle is dropped even if `o_in_ready`=1. An output handshake in the flush cycle still counts as delivered.

## Timing
- Reset (async assert, sync release): M.valid=S.valid=0, `o_valid`=0, `o_in_ready`=1, `o_take`=0, `o_mispredict`=0, `o_target`=`o_next_pc`=0, counters 0. Inputs ignored while `i_rst_n`=0.
- Reset mid-operation discards both entries immediately.
- Latency: accept in cycle N -> `o_valid` in cycle N+1 when M empty.
- Throughput: 1 result/cycle with `i_out_ready` held high.
- Full: both entries valid -> `o_in_ready`=0 in the following cycle; recovers to 1 the cycle after M is consumed.
- No combinational path from `i_out_ready` to `o_in_ready`.

## Configuration
- `BU_PIPE_STATS_EN` defined: `o_stat_resolved` increments on every output handshake; `o_stat_mispredict` increments on handshakes with `o_mispredict`=1. Both saturate at 32'hFFFF_FFFF; cleared only by reset.
- Undefined: counter logic absent; both stat ports tied to 0. All other behaviour identical.

## Test plan
- a=1,b=1,BU_EQ,pc=0x100,imm=0x20,pred=0 -> next cycle o_valid=1, take=1, target=0x120, next_pc=0x120, mispredict=1.
- a=-1,b=3: BU_LTU -> take=0, next_pc=pc+4; BU_LT -> take=1; BU_GEU -> take=1; BU_GE -> take=0.
- pc=0xFFFF_FFF0, imm=0x20, i_jump=1 -> target=0x0000_0010, take=1 (wrap).
- i_out_ready=0, three back-to-back requests -> first two accepted, o_in_ready=0 from cycle after the second; release ready -> results drain in order, payload stable while stalled.
- Both entries full, i_flush=1 with i_valid=1 -> next cycle o_valid=0, o_in_ready=1, incoming entry not delivered.
- With BU_PIPE_STATS_EN: 5 handshakes, 2 mispredicted -> o_stat_resolved=5, o_stat_mispredict=2; flushed entries not counted; without macro both read 0.
